// File: rtl/rf_param.sv
// Parametrised two-read/one-write register file with pending scoreboard bits,
// optional zero register, optional write-to-read bypass and a sequenced clear engine.
module rf_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              RF_w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] r_addr_0,
  input  logic [ADDR_W-1:0] r_addr_1,
  output logic [DATA_W-1:0] o_r_data_0,
  output logic [DATA_W-1:0] o_r_data_1,
  output logic              o_pend_0,
  output logic              o_pend_1
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0]    r_pend;

  logic w_wr_ok;
  logic w_rsv_ok;
  logic w_byp_0;
  logic w_byp_1;
  logic w_zero_0;
  logic w_zero_1;

  assign clr_busy = (r_state == S_CLEAR);

  // Clear engine state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Clear engine next-state: sweep one register per cycle, DEPTH cycles total
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_wr_ok  = RF_w_en && !clr_busy && !(ZERO_REG && (w_addr == '0));
  assign w_rsv_ok = rsv_en  && !clr_busy && !(ZERO_REG && (rsv_addr == '0));

  // Storage and scoreboard; reservation is written last so it wins over a same-address write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_pend <= '0;
    end else if (clr_busy) begin
      r_mem[r_cnt]  <= '0;
      r_pend[r_cnt] <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_mem[w_addr]  <= w_data;
        r_pend[w_addr] <= 1'b0;
      end
      if (w_rsv_ok) begin
        r_pend[rsv_addr] <= 1'b1;
      end
    end
  end

  assign w_byp_0  = BYPASS && w_wr_ok && (w_addr == r_addr_0);
  assign w_byp_1  = BYPASS && w_wr_ok && (w_addr == r_addr_1);
  assign w_zero_0 = ZERO_REG && (r_addr_0 == '0);
  assign w_zero_1 = ZERO_REG && (r_addr_1 == '0);

  // Combinational read ports
  always_comb begin
    o_r_data_0 = w_byp_0 ? w_data : r_mem[r_addr_0];
    o_r_data_1 = w_byp_1 ? w_data : r_mem[r_addr_1];
    o_pend_0   = r_pend[r_addr_0];
    o_pend_1   = r_pend[r_addr_1];
    if (w_zero_0) begin
      o_r_data_0 = '0;
      o_pend_0   = 1'b0;
    end
    if (w_zero_1) begin
      o_r_data_1 = '0;
      o_pend_1   = 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_param.sv
// Bench for rf_param: a default instance (8x8, zero reg, bypass) and a 16x16 instance
// (no zero reg, no bypass) share stimulus and are checked against a behavioural model.
module tb_rf_param;

  logic        clk;
  logic        rst;
  logic        clr_req;
  logic        we;
  logic        rsv;
  logic [3:0]  wa;
  logic [3:0]  ra;
  logic [3:0]  r0;
  logic [3:0]  r1;
  logic [15:0] wd;

  logic        busy0, busy1;
  logic [7:0]  d0_0, d0_1;
  logic [15:0] d1_0, d1_1;
  logic        p0_0, p0_1, p1_0, p1_1;

  int total = 0;
  int bad   = 0;

  int unsigned m_mem  [2][16];
  bit          m_pend [2][16];
  bit          m_busy [2];
  int unsigned m_idx  [2];

  rf_param u0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy0),
    .RF_w_en(we), .w_addr(wa[2:0]), .w_data(wd[7:0]),
    .rsv_en(rsv), .rsv_addr(ra[2:0]),
    .r_addr_0(r0[2:0]), .r_addr_1(r1[2:0]),
    .o_r_data_0(d0_0), .o_r_data_1(d0_1), .o_pend_0(p0_0), .o_pend_1(p0_1)
  );

  rf_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) u1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy1),
    .RF_w_en(we), .w_addr(wa), .w_data(wd),
    .rsv_en(rsv), .rsv_addr(ra),
    .r_addr_0(r0), .r_addr_1(r1),
    .o_r_data_0(d1_0), .o_r_data_1(d1_1), .o_pend_0(p1_0), .o_pend_1(p1_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Configuration 0 = 8 regs x 8 bits, zero reg, bypass; 1 = 16 x 16, plain
  function automatic int unsigned amask(input int c);
    return (c == 0) ? 32'd7 : 32'd15;
  endfunction
  function automatic int unsigned dmask(input int c);
    return (c == 0) ? 32'hFF : 32'hFFFF;
  endfunction

  function automatic logic [31:0] exp_data(input int c, input logic [3:0] a);
    int unsigned am  = a & amask(c);
    int unsigned wam = wa & amask(c);
    if (c == 0 && am == 0) return 32'd0;
    if (c == 0 && we && !m_busy[c] && wam == am) return wd & dmask(c);
    return m_mem[c][am];
  endfunction

  function automatic logic [31:0] exp_pend(input int c, input logic [3:0] a);
    int unsigned am = a & amask(c);
    if (c == 0 && am == 0) return 32'd0;
    return {31'd0, m_pend[c][am]};
  endfunction

  // Apply one clock edge to the model using the currently driven inputs
  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      int unsigned depth = amask(c) + 1;
      int unsigned wam   = wa & amask(c);
      int unsigned ram   = ra & amask(c);
      if (rst) begin
        for (int i = 0; i < 16; i++) begin
          m_mem[c][i]  = 0;
          m_pend[c][i] = 1'b0;
        end
        m_busy[c] = 1'b0;
        m_idx[c]  = 0;
      end else if (m_busy[c]) begin
        m_mem[c][m_idx[c]]  = 0;
        m_pend[c][m_idx[c]] = 1'b0;
        m_idx[c]++;
        if (m_idx[c] == depth) m_busy[c] = 1'b0;
      end else begin
        if (clr_req) begin
          m_busy[c] = 1'b1;
          m_idx[c]  = 0;
        end
        if (we && !(c == 0 && wam == 0)) begin
          m_mem[c][wam]  = wd & dmask(c);
          m_pend[c][wam] = 1'b0;
        end
        if (rsv && !(c == 0 && ram == 0)) m_pend[c][ram] = 1'b1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    chk("busy0", {31'd0, busy0}, {31'd0, m_busy[0]});
    chk("busy1", {31'd0, busy1}, {31'd0, m_busy[1]});
    chk("u0_data0", {24'd0, d0_0}, exp_data(0, r0));
    chk("u0_data1", {24'd0, d0_1}, exp_data(0, r1));
    chk("u0_pend0", {31'd0, p0_0}, exp_pend(0, r0));
    chk("u0_pend1", {31'd0, p0_1}, exp_pend(0, r1));
    chk("u1_data0", {16'd0, d1_0}, exp_data(1, r0));
    chk("u1_data1", {16'd0, d1_1}, exp_data(1, r1));
    chk("u1_pend0", {31'd0, p1_0}, exp_pend(1, r0));
    chk("u1_pend1", {31'd0, p1_1}, exp_pend(1, r1));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc();
    sample();
    tick();
  endtask

  task automatic idle();
    rst = 1'b0; clr_req = 1'b0; we = 1'b0; rsv = 1'b0;
  endtask

  task automatic rand_in(input bit allow_ctl);
    we  = ($urandom_range(0, 1) == 1);
    rsv = ($urandom_range(0, 9) < 3);
    wa  = 4'($urandom);
    ra  = 4'($urandom);
    r0  = 4'($urandom);
    r1  = 4'($urandom);
    wd  = 16'($urandom);
    clr_req = allow_ctl && ($urandom_range(0, 49) == 0);
    rst     = allow_ctl && ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    int nbusy;
    idle();
    wa = 0; ra = 0; r0 = 0; r1 = 0; wd = 0;
    for (int c = 0; c < 2; c++) begin
      m_busy[c] = 1'b0; m_idx[c] = 0;
      for (int i = 0; i < 16; i++) begin m_mem[c][i] = 0; m_pend[c][i] = 1'b0; end
    end
    rst = 1'b1;
    tick();
    idle();

    // Reset clears a written register
    we = 1'b1; wa = 4'd3; wd = 16'h00A5;
    cyc();
    idle(); r0 = 4'd3;
    sample();
    chk("pre_rst_reg3", {24'd0, d0_0}, 32'hA5);
    tick();
    rst = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      r0 = 4'(i); r1 = 4'(i);
      sample();
      chk("rst_data0", {24'd0, d0_0}, 32'h0);
      chk("rst_data1", {24'd0, d0_1}, 32'h0);
      chk("rst_pend", {30'd0, p0_0, p0_1}, 32'h0);
      chk("rst_busy", {31'd0, busy0}, 32'h0);
      tick();
    end

    // Zero register vs. plain register 0
    we = 1'b1; wa = 4'd0; wd = 16'h00FF; rsv = 1'b1; ra = 4'd0;
    cyc();
    idle(); r0 = 4'd0;
    sample();
    chk("zr_data", {24'd0, d0_0}, 32'h0);
    chk("zr_pend", {31'd0, p0_0}, 32'h0);
    chk("nozr_data", {16'd0, d1_0}, 32'hFF);
    chk("nozr_pend", {31'd0, p1_0}, 32'h1);
    tick();

    // Same-cycle bypass only on the bypassing instance
    we = 1'b1; wa = 4'd5; wd = 16'h003C; r1 = 4'd5;
    sample();
    chk("byp_on", {24'd0, d0_1}, 32'h3C);
    chk("byp_off_old", {16'd0, d1_1}, 32'h0);
    tick();
    idle();
    sample();
    chk("byp_off_new", {16'd0, d1_1}, 32'h3C);
    tick();

    // Scoreboard set, clear by write, reserve wins over same-address write
    rsv = 1'b1; ra = 4'd2; r0 = 4'd2;
    cyc();
    idle();
    sample();
    chk("rsv_pend", {31'd0, p0_0}, 32'h1);
    tick();
    we = 1'b1; wa = 4'd2; wd = 16'h0011;
    cyc();
    idle();
    sample();
    chk("wr_clr_pend", {31'd0, p0_0}, 32'h0);
    chk("wr_data", {24'd0, d0_0}, 32'h11);
    tick();
    we = 1'b1; wa = 4'd4; wd = 16'h0077; rsv = 1'b1; ra = 4'd4; r0 = 4'd4;
    cyc();
    idle();
    sample();
    chk("wr_rsv_data", {24'd0, d0_0}, 32'h77);
    chk("wr_rsv_pend", {31'd0, p0_0}, 32'h1);
    tick();

    // Full clear sweep on the 16-entry instance
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wa = 4'(i); wd = 16'(32'h1234 + i);
      cyc();
    end
    idle(); clr_req = 1'b1;
    cyc();
    idle();
    nbusy = 0;
    for (int n = 0; n < 16; n++) begin
      we = 1'b1; wa = 4'($urandom); wd = 16'($urandom); clr_req = 1'b1;
      r0 = 4'(n); r1 = 4'(n - 1);
      sample();
      if (busy1) nbusy++;
      chk("sweep_pre", {16'd0, d1_0}, 32'h1234 + n);
      if (n > 0) chk("sweep_done", {16'd0, d1_1}, 32'h0);
      tick();
    end
    idle();
    sample();
    chk("sweep_len", nbusy, 32'd16);
    chk("sweep_end", {31'd0, busy1}, 32'h0);
    tick();
    we = 1'b1; wa = 4'd9; wd = 16'hBEEF; r0 = 4'd9;
    cyc();
    idle();
    sample();
    chk("post_sweep_wr", {16'd0, d1_0}, 32'hBEEF);
    tick();

    // Reset in the middle of a sweep
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wa = 4'(i); wd = 16'(32'h1234 + i);
      cyc();
    end
    idle(); clr_req = 1'b1;
    cyc();
    for (int n = 0; n < 7; n++) begin
      rand_in(1'b0);
      cyc();
    end
    idle(); rst = 1'b1; we = 1'b1; wa = 4'd15; wd = 16'h5555; clr_req = 1'b1;
    cyc();
    idle(); r0 = 4'd15; r1 = 4'd12;
    sample();
    chk("rst_sweep_busy", {31'd0, busy1}, 32'h0);
    chk("rst_sweep_r15", {16'd0, d1_0}, 32'h0);
    chk("rst_sweep_r12", {16'd0, d1_1}, 32'h0);
    tick();

    // Random regression
    for (int n = 0; n < 1000; n++) begin
      rand_in(1'b1);
      cyc();
    end
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_param.md
# rf_param

Parametrised register file for the next-generation CPU datapath. It replaces the fixed 8x8-bit, two-read/one-write file with a configurable width and depth, an optional hard-wired zero register and optional same-cycle write-to-read bypass. It adds a per-register pending (scoreboard) bit for pipelined hazard detection and a sequenced, one-register-per-cycle clear engine. It sits between decode (read/reserve) and writeback (write).

## Interface

- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and reservations
- BYPASS, 1, 1 = a write in the current cycle is forwarded to matching read ports combinationally

Ports:

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- clr_req  in  1  start sequenced clear (sampled in IDLE only)
- clr_busy  out  1  high while the clear engine runs
- RF_w_en  in  1  write enable
- w_addr  in  ADDR_W  write address
- w_data  in  DATA_W  write data
- rsv_en  in  1  reserve (set pending bit of) rsv_addr
- rsv_addr  in  ADDR_W  reservation address
- r_addr_0, r_addr_1  in  ADDR_W  read addresses
- o_r_data_0, o_r_data_1  out  DATA_W  read data, combinational
- o_pend_0, o_pend_1  out  1  pending bit of r_addr_0 / r_addr_1, combinational

## Operation

- Storage: DEPTH x DATA_W registers plus a DEPTH-bit pending vector.
- Read: o_r_data_n = reg[r_addr_n]; o_pend_n = pend[r_addr_n]. With ZERO_REG, address 0 returns 0 data and 0 pending.
- Bypass (BYPASS=1): if RF_w_en, clr_busy=0, w_addr==r_addr_n and the address is not the zero register, o_r_data_n = w_data in the same cycle. With BYPASS=0 the new value is visible only after the edge.
- Write: at the edge, if RF_w_en and clr_busy=0 and the address is not the zero register: reg[w_addr] <= w_data and pend[w_addr] <= 0.
- Reserve: at the edge, if rsv_en and clr_busy=0 and the address is not the zero register: pend[rsv_addr] <= 1.
- Write and reserve to the same address in the same cycle: data is written and pend ends at 1, so the reservation wins.
- Clear engine FSM, states IDLE and CLEAR, with counter cnt[ADDR_W-1:0]:
  - IDLE: if clr_req, go to CLEAR with cnt <= 0.
  - CLEAR: each edge, reg[cnt] <= 0, pend[cnt] <= 0, cnt <= cnt+1. At cnt==DEPTH-1, the clear happens and the FSM returns to IDLE.
  - clr_busy = (state==CLEAR).
  - RF_w_en, rsv_en and clr_req are ignored while in CLEAR.
  - Reads remain live during CLEAR. Bypass is disabled during CLEAR.
- Priority: rst > clear engine > write/reserve.

## Timing

- Reset: at an edge with rst=1, all registers and pending bits go to 0, state goes to IDLE, cnt to 0 and clr_busy to 0.
  - Outputs read 0 from the next cycle.
  - rst during CLEAR aborts the sweep; everything is cleared anyway.
  - rst overrides a simultaneous write, reservation or clr_req.
- Write latency: 1 edge to storage; 0 cycles to a read port with BYPASS=1.
- Pending: set/clear becomes visible on o_pend_n the cycle after the edge. There is no pending bypass.
- Clear: clr_req sampled at edge k puts clr_busy high from after edge k through edge k+DEPTH (DEPTH cycles).
  - Register i is 0 after edge k+1+i.
  - IDLE and writes are accepted again from the cycle after edge k+DEPTH.
- cnt wraps naturally at DEPTH-1 and is never observed outside CLEAR.
- Combinational read paths: address to data with no registered stage.

## Test plan

- Reset: write reg3=0xA5, then rst=1 for one edge -> all 8 registers read 0x00 on both ports; o_pend_0/1=0; clr_busy=0.
- Zero register: write 0xFF to addr 0 and rsv addr 0 -> o_r_data_0=0x00 and o_pend_0=0 for addr 0. Repeat with ZERO_REG=0 -> reads 0xFF, pend=1.
- Bypass: RF_w_en=1, w_addr=5, w_data=0x3C, r_addr_1=5 -> o_r_data_1=0x3C in the same cycle (BYPASS=1); old value until the edge with BYPASS=0.
- Scoreboard:
  - rsv 2 -> o_pend for addr 2 is 1 next cycle.
  - Write 2=0x11 -> pend is 0 next cycle and data is 0x11.
  - Simultaneous write 4 and rsv 4 -> data written and pend=1.
- Clear sweep, DATA_W=16, ADDR_W=4: fill all registers with 0x1234+i, pulse clr_req -> clr_busy high for exactly 16 cycles and reg i reads 0 after edge k+1+i.
  - A write attempted during the sweep has no effect.
  - rst at cycle 7 of the sweep -> all zero and clr_busy=0 next cycle.
- Random regression: 1000 cycles of random RF_w_en/rsv_en/addresses/data and occasional clr_req against a reference model -> every read port matches the model every cycle.
